// File: rtl/score_accum_pkg.sv
// Shared types and defaults for the multi-team score accumulator.
package score_pkg;
  localparam int PTS_W         = 2;
  localparam int DEF_WIDTH     = 7;
  localparam int DEF_MAX_SCORE = 127;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    WRITE = 2'd2
  } state_t;
endpackage

// File: rtl/score_accum_addsub_sat.sv
// Combinational add/subtract of a 0..3 point operand with clamping to [0, MAX_SCORE].
module addsub_sat
  import score_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_SCORE = DEF_MAX_SCORE
) (
  input  logic [WIDTH-1:0] score,
  input  logic [PTS_W-1:0] pts,
  input  logic             sub,
  output logic [WIDTH-1:0] result,
  output logic             clamp
);

  localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MAX_SCORE);

  logic [WIDTH:0] ext_score;
  logic [WIDTH:0] ext_pts;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // One guard bit: the sum can pass MAX_SCORE and the difference can borrow.
  always_comb begin
    ext_score = {1'b0, score};
    ext_pts   = (WIDTH+1)'(pts);
    sum       = ext_score + ext_pts;
    diff      = ext_score - ext_pts;
    result    = score;
    clamp     = 1'b0;
    if (sub) begin
      if (diff[WIDTH]) begin
        result = '0;
        clamp  = 1'b1;
      end else begin
        result = diff[WIDTH-1:0];
      end
    end else begin
      if (sum > MAX_EXT) begin
        result = MAX_EXT[WIDTH-1:0];
        clamp  = 1'b1;
      end else begin
        result = sum[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/score_accum.sv
// Registered multi-team score accumulator with valid/ready updates and saturation.
// Optional one-level per-team undo history enabled by SCORE_ACCUM_UNDO_EN.
//   state | meaning
//   IDLE  | ready, waiting for an update request
//   CALC  | compute result/clamp for the captured request
//   WRITE | commit result or reject, pulse done/err
module score_accum
  import score_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int N_TEAMS   = 2,
  parameter int MAX_SCORE = DEF_MAX_SCORE,
  parameter int TEAM_W    = (N_TEAMS > 1) ? $clog2(N_TEAMS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     upd_valid,
  output logic                     upd_ready,
  input  logic [TEAM_W-1:0]        upd_team,
  input  logic [PTS_W-1:0]         upd_pts,
  input  logic                     upd_sub,
  input  logic                     upd_undo,
  output logic                     upd_done,
  output logic                     upd_err,
  output logic [N_TEAMS*WIDTH-1:0] score,
  output logic [N_TEAMS-1:0]       sat_flag
);

  state_t state_q, state_d;

  logic [TEAM_W-1:0] req_team;
  logic [PTS_W-1:0]  req_pts;
  logic              req_sub;
  logic              req_undo;

  logic [WIDTH-1:0]  res_q;
  logic              clamp_q;
  logic              rej_q;

  logic [WIDTH-1:0]  cur_score;
  logic              team_ok;
  logic [WIDTH-1:0]  hist_sel;
  logic              hist_ok;
  logic [WIDTH-1:0]  as_result;
  logic              as_clamp;

`ifdef SCORE_ACCUM_UNDO_EN
  logic [WIDTH-1:0]   hist_q [N_TEAMS];
  logic [N_TEAMS-1:0] hist_v;
`endif

  always_ff @(posedge clk) begin
    if (rst || clr) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    upd_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        upd_ready = 1'b1;
        if (upd_valid) state_d = CALC;
      end
      CALC:    state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Out-of-range team indices match nothing, leaving team_ok low.
  always_comb begin
    cur_score = '0;
    team_ok   = 1'b0;
    hist_sel  = '0;
    hist_ok   = 1'b0;
    for (int i = 0; i < N_TEAMS; i++) begin
      if (req_team == TEAM_W'(i)) begin
        cur_score = score[i*WIDTH +: WIDTH];
        team_ok   = 1'b1;
`ifdef SCORE_ACCUM_UNDO_EN
        hist_sel  = hist_q[i];
        hist_ok   = hist_v[i];
`endif
      end
    end
  end

  addsub_sat #(
    .WIDTH     (WIDTH),
    .MAX_SCORE (MAX_SCORE)
  ) u_addsub_sat (
    .score  (cur_score),
    .pts    (req_pts),
    .sub    (req_sub),
    .result (as_result),
    .clamp  (as_clamp)
  );

  always_ff @(posedge clk) begin
    upd_done <= 1'b0;
    upd_err  <= 1'b0;
    if (rst || clr) begin
      score    <= '0;
      sat_flag <= '0;
      req_team <= '0;
      req_pts  <= '0;
      req_sub  <= 1'b0;
      req_undo <= 1'b0;
      res_q    <= '0;
      clamp_q  <= 1'b0;
      rej_q    <= 1'b0;
`ifdef SCORE_ACCUM_UNDO_EN
      hist_v   <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (upd_valid) begin
            req_team <= upd_team;
            req_pts  <= upd_pts;
            req_sub  <= upd_sub;
            req_undo <= upd_undo;
          end
        end
        CALC: begin
          res_q   <= req_undo ? hist_sel : as_result;
          clamp_q <= req_undo ? 1'b0 : as_clamp;
          rej_q   <= !team_ok || (req_undo && !hist_ok);
        end
        WRITE: begin
          if (rej_q) begin
            upd_err <= 1'b1;
          end else begin
            upd_done <= 1'b1;
            for (int i = 0; i < N_TEAMS; i++) begin
              if (req_team == TEAM_W'(i)) begin
                score[i*WIDTH +: WIDTH] <= res_q;
                if (!req_undo) sat_flag[i] <= sat_flag[i] | clamp_q;
`ifdef SCORE_ACCUM_UNDO_EN
                // An undo consumes the history so a second undo is rejected.
                if (req_undo) begin
                  hist_v[i] <= 1'b0;
                end else begin
                  hist_q[i] <= score[i*WIDTH +: WIDTH];
                  hist_v[i] <= 1'b1;
                end
`endif
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_score_accum.sv
// Directed self-checking bench for score_accum (2 teams, 7-bit scores, 2-bit team index).
module tb_score_accum;
  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        upd_valid;
  logic        upd_ready;
  logic [1:0]  upd_team;
  logic [1:0]  upd_pts;
  logic        upd_sub;
  logic        upd_undo;
  logic        upd_done;
  logic        upd_err;
  logic [13:0] score;
  logic [1:0]  sat_flag;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Index widened to 2 bits so an out-of-range team (2) can be requested.
  score_accum #(
    .WIDTH     (7),
    .N_TEAMS   (2),
    .MAX_SCORE (127),
    .TEAM_W    (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .upd_valid (upd_valid),
    .upd_ready (upd_ready),
    .upd_team  (upd_team),
    .upd_pts   (upd_pts),
    .upd_sub   (upd_sub),
    .upd_undo  (upd_undo),
    .upd_done  (upd_done),
    .upd_err   (upd_err),
    .score     (score),
    .sat_flag  (sat_flag)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one request and check the ready/done/err timeline around it.
  task automatic upd(input logic [1:0] team, input logic [1:0] pts, input logic sub,
                     input logic undo, input logic exp_err);
    int n = 0;
    @(negedge clk);
    while (!upd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", upd_ready, 1);
    upd_valid = 1'b1;
    upd_team  = team;
    upd_pts   = pts;
    upd_sub   = sub;
    upd_undo  = undo;
    @(posedge clk);
    #1 upd_valid = 1'b0;
    @(negedge clk);
    check("ready_t0", upd_ready, 0);
    check("done_t0", upd_done, 0);
    @(negedge clk);
    check("ready_t1", upd_ready, 0);
    check("done_t1", upd_done | upd_err, 0);
    @(negedge clk);
    check("done_t2", upd_done, !exp_err);
    check("err_t2", upd_err, exp_err);
    check("ready_t2", upd_ready, 1);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; upd_valid = 1'b0;
    upd_team = '0; upd_pts = '0; upd_sub = 1'b0; upd_undo = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_score", score, 0);
    check("rst_sat", sat_flag, 0);
    check("rst_ready", upd_ready, 1);
    check("rst_done", upd_done, 0);
    check("rst_err", upd_err, 0);

    upd(2'd0, 2'd3, 1'b0, 1'b0, 1'b0);
    check("t0_plus3", score[6:0], 3);
    upd(2'd1, 2'd2, 1'b0, 1'b0, 1'b0);
    check("t1_plus2", score[13:7], 2);
    check("t0_keep", score[6:0], 3);

    for (int i = 0; i < 41; i++) upd(2'd0, 2'd3, 1'b0, 1'b0, 1'b0);
    check("t0_126", score[6:0], 126);
    check("sat_126", sat_flag, 0);
    upd(2'd0, 2'd3, 1'b0, 1'b0, 1'b0);
    check("t0_clamp", score[6:0], 127);
    check("sat0_set", sat_flag, 2'b01);
    check("t1_untouched", score[13:7], 2);

    pulse_clr();
    check("clr_score", score, 0);
    check("clr_sat", sat_flag, 0);

    upd(2'd1, 2'd1, 1'b0, 1'b0, 1'b0);
    upd(2'd1, 2'd2, 1'b1, 1'b0, 1'b0);
    check("t1_sub_clamp", score[13:7], 0);
    check("sat1_set", sat_flag, 2'b10);
    pulse_clr();
    upd(2'd1, 2'd2, 1'b0, 1'b0, 1'b0);
    upd(2'd1, 2'd2, 1'b1, 1'b0, 1'b0);
    check("t1_sub_exact", score[13:7], 0);
    check("sat1_exact", sat_flag, 0);

    upd(2'd0, 2'd1, 1'b0, 1'b0, 1'b0);
    upd(2'd2, 2'd3, 1'b0, 1'b0, 1'b1);
    check("bad_team", score, 14'd1);
    upd(2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    check("pts0", score, 14'd1);
    pulse_clr();

    // Reset while the +2 request sits in CALC.
    @(negedge clk);
    upd_valid = 1'b1; upd_team = 2'd0; upd_pts = 2'd2; upd_sub = 1'b0; upd_undo = 1'b0;
    @(posedge clk);
    #1 upd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rstcalc_ready", upd_ready, 1);
    check("rstcalc_score", score, 0);
    for (int i = 0; i < 3; i++) begin
      check("rstcalc_nodone", upd_done | upd_err, 0);
      @(negedge clk);
    end
    check("rstcalc_final", score, 0);

    for (int i = 0; i < 3; i++) upd(2'd0, 2'd3, 1'b0, 1'b0, 1'b0);
    upd(2'd0, 2'd1, 1'b0, 1'b0, 1'b0);
    check("t0_10", score[6:0], 10);
    upd(2'd0, 2'd3, 1'b0, 1'b0, 1'b0);
    check("t0_13", score[6:0], 13);
`ifdef SCORE_ACCUM_UNDO_EN
    upd(2'd0, 2'd2, 1'b1, 1'b1, 1'b0);
    check("undo_restore", score[6:0], 10);
    upd(2'd0, 2'd0, 1'b0, 1'b1, 1'b1);
    check("undo_twice", score[6:0], 10);
    upd(2'd1, 2'd0, 1'b0, 1'b1, 1'b1);
    check("undo_nohist", score[13:7], 0);
`else
    upd(2'd0, 2'd3, 1'b0, 1'b1, 1'b1);
    check("undo_off", score[6:0], 13);
`endif
    check("final_sat", sat_flag, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/score_accum.md
Name: score_accum

Overview:
- Registered, parametrised multi-team score accumulator for the basketball scoreboard.
- Successor to the combinational 7-bit add/subtract-by-1/2/3 path, adding:
  - N independent team registers;
  - a valid/ready update handshake;
  - a small FSM;
  - saturation at 0 and at MAX_SCORE;
  - sticky saturation flags.
- Sits between the button/debounce logic and the BCD/7-segment display drivers.

Parameters:
- WIDTH, 7: bits per team score.
- N_TEAMS, 2: number of independent score channels.
- MAX_SCORE, 127: upper clamp. Must be ≤ 2**WIDTH-1.
- TEAM_W, $clog2(N_TEAMS) (min 1): width of the team index.

Ports:
- clk, input, 1: single clock. All logic is on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- clr, input, 1: synchronous clear of all scores and flags (new match).
- upd_valid, input, 1: update request valid.
- upd_ready, output, 1: block can accept an update.
- upd_team, input, TEAM_W: target team index.
- upd_pts, input, 2: points (0..3).
- upd_sub, input, 1: 1 = subtract (correction), 0 = add.
- upd_undo, input, 1: revert the team's last committed update (see Optional Feature).
- upd_done, output, 1: one-cycle pulse when the update commits.
- upd_err, output, 1: one-cycle pulse when an accepted update is rejected.
- score, output, N_TEAMS*WIDTH: packed scores. Team i is at [i*WIDTH +: WIDTH].
- sat_flag, output, N_TEAMS: sticky per team. Set when a clamp occurred.

Behaviour:
- Reset (rst=1 at an edge):
  - all score=0, sat_flag=0, upd_done=0, upd_err=0, upd_ready=1;
  - FSM goes to IDLE;
  - undo history is invalidated.
  - rst dominates clr and any in-flight update.
- clr:
  - same effect as rst on score, sat_flag, history and FSM;
  - an in-flight update is aborted, with no done and no err.
- FSM states:
  - IDLE:
    - upd_ready=1.
    - Handshake: when upd_valid & upd_ready, capture team, pts, sub and undo into request registers and go to CALC.
  - CALC:
    - upd_ready=0.
    - The addsub_sat instance computes the result from the captured request and the current team score.
    - The result and clamp bit are registered, then go to WRITE.
  - WRITE:
    - upd_ready=0.
    - Commit the result to score[team]; OR the clamp bit into sat_flag[team]; pulse upd_done; go to IDLE.
- Latency and throughput:
  - acceptance at edge T; score is visible after edge T+2; upd_done is high during cycle T+2..T+3;
  - at most one update per 3 cycles.
- Arithmetic:
  - computed in WIDTH+1 bits;
  - add: result = min(score+pts, MAX_SCORE);
  - sub: result = max(score-pts, 0);
  - clamp=1 only when the limit actually cut the result. Exactly reaching the limit does not set clamp.
- upd_pts=0: normal flow, score unchanged, upd_done pulses.
- upd_team ≥ N_TEAMS:
  - accepted, then in WRITE: no score change, upd_err pulses instead of upd_done.
- upd_valid while upd_ready=0: ignored. The requester must hold valid until ready.
- Other teams' scores never change during an update.

Optional Feature:
- Macro: SCORE_ACCUM_UNDO_EN.
- With the macro:
  - per team, a one-level history register holds the pre-commit score and a valid bit;
  - every committed non-undo update (including pts=0) stores the history and sets the valid bit;
  - an update with upd_undo=1 ignores pts and sub, and restores the history value in WRITE, with upd_done;
  - sat_flag is unchanged by an undo;
  - after an undo, or with no history, a further undo commits nothing and pulses upd_err;
  - clr and rst invalidate the history.
- Without the macro:
  - no history storage;
  - any update with upd_undo=1 is accepted, changes nothing, and pulses upd_err.

Decomposition:
- Package score_pkg:
  - state enum (IDLE, CALC, WRITE);
  - localparams for pts width (2) and the default WIDTH and MAX_SCORE.
- Sub-module addsub_sat, parametrised by WIDTH and MAX_SCORE:
  - combinational add/subtract of a 2-bit operand with clamp;
  - inputs: score, pts, sub;
  - outputs: result, clamp;
  - instantiated once and shared across teams through a mux on the captured team.

Test Plan:
- Reset, then team0 +3 and team1 +2 → score0=3, score1=2; each upd_done arrives exactly 2 cycles after acceptance; upd_ready is low for 2 cycles per update.
- score0=126, +3 → score0=127, sat_flag[0]=1. Then clr → all scores 0, flags 0.
- score1=1, sub 2 → score1=0, sat_flag[1]=1. Separately, score1=2, sub 2 → 0 with the flag staying 0.
- upd_team=2 with N_TEAMS=2 → upd_err pulse, scores unchanged. upd_pts=0 → upd_done pulse, no change.
- rst asserted in CALC after a +2 request → score stays 0, no upd_done, upd_ready=1 the next cycle.
- UNDO_EN: score0=10, +3 → 13, then undo → 10 with done; a second undo → err, score stays 10. Macro off: undo → err, score unchanged.
